hasher_selftest_seq: RTL and testbench
======================================

# hasher_selftest_seq

On-chip, synthesizable self-test sequencer for the serial hasher array. On `start` it loads the known-answer work unit into NUM_CORES hasher cores, giving each core a start nonce a few steps below the known golden nonce. It then monitors each core's golden-nonce report and flags per-core pass/fail, with a timeout. It sits between the work-loading mux and the cores, and its results are visible on LEDs/UART status.

## Interface
Parameters:
- NUM_CORES, 2, number of hasher cores under test (1..16)
- MIDSTATE, 256'h85a24391639705f42f64b3b688df3d147445123c323e62143d87e1908b3f07ef, known-answer midstate
- DATA, 96'hc513051a02a99050bfec0373, known-answer tail data (96 bits)
- EXPECTED_NONCE, 32'h1afda099, golden nonce the vector must produce
- BACKOFF, 2, base start offset below EXPECTED_NONCE
- TIMEOUT_CYCLES, 4096, RUN-state cycle limit (must be < 2^16)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  level, sampled in IDLE/DONE; begins a test
- load_out  out  NUM_CORES  one-cycle load strobe per core
- midstate_out  out  256  equals MIDSTATE (constant)
- data_out  out  96  equals DATA (constant)
- nonce_load_out  out  32*NUM_CORES  start nonce for core k in bits [32k+31:32k]
- golden_valid_in  in  NUM_CORES  core k reports a found nonce
- golden_nonce_in  in  32*NUM_CORES  reported nonce, core k slice
- busy  out  1  high in LOAD and RUN
- done  out  1  high in DONE
- pass_mask  out  NUM_CORES  core reported EXPECTED_NONCE
- fail_mask  out  NUM_CORES  core reported a wrong nonce or timed out
- elapsed_out  out  16  RUN-cycle count at the last core's decision, or at timeout

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: `start`=1 -> LOAD. Masks, elapsed counter and cycle counter are cleared on this transition.
- LOAD: exactly one cycle.
  - `load_out` is all ones.
  - `nonce_load_out` slice k = EXPECTED_NONCE - BACKOFF - k, as modulo-2^32 subtraction (wraps through 0).
  - Next state is RUN.
- RUN: the cycle counter increments every cycle, starting at 0 in the first RUN cycle.
  - Per core, the first `golden_valid_in[k]` decides the core. If the nonce equals EXPECTED_NONCE, set pass_mask[k]; otherwise set fail_mask[k].
  - Later reports from an already-decided core are ignored.
  - Several cores may decide in the same cycle; all are recorded.
  - When the last undecided core decides, latch elapsed_out = counter and go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with cores still undecided: any valid reports in that cycle are evaluated first; every core still undecided gets its fail bit; elapsed_out = TIMEOUT_CYCLES-1; go to DONE.
- DONE: results held stable. `start`=1 -> LOAD, clearing masks and elapsed_out.
- `start` is ignored in LOAD and RUN. `golden_valid_in` is ignored outside RUN.
- Invariant: pass_mask & fail_mask == 0 at all times.
- In DONE, pass_mask | fail_mask == all ones.
- Reset, asynchronous and valid at any time including mid-RUN: state -> IDLE. All outputs go to 0 except `midstate_out`/`data_out`, which stay constant. Stale reports arriving after reset are ignored.

## Timing
- Reset values:
  - load_out 0, nonce_load_out 0, busy 0, done 0
  - pass_mask 0, fail_mask 0, elapsed_out 0
- All outputs are registered except the constant midstate_out/data_out.
- `start` high at edge N (in IDLE) gives:
  - LOAD with load_out=all ones and busy=1 during cycle N+1
  - RUN from cycle N+2, counter=0
- nonce_load_out is valid in the LOAD cycle and holds until the next LOAD or reset.
- A deciding report at RUN counter value c gives:
  - the mask bit visible the following cycle
  - if it is the final decision, done=1, busy=0 and elapsed_out=c the following cycle
- Minimum test length: 1 LOAD + 1 RUN cycle. With all cores reporting in RUN cycle 0, done rises 3 cycles after start is sampled.

## Test plan
- NUM_CORES=2, start pulse; stub cores report 32'h1afda099 at RUN cycles 5 and 9 -> load_out=2'b11 for one cycle; nonces 1afda097/1afda096; pass_mask=2'b11, fail_mask=0, elapsed_out=9, done=1.
- Core0 reports 32'h1afda0af at cycle 3, then 1afda099 at cycle 4; core1 reports 1afda099 at cycle 4 -> fail_mask=2'b01, pass_mask=2'b10 (the later core0 report is ignored), elapsed_out=4.
- TIMEOUT_CYCLES=16; core1 never reports; core0 passes at cycle 15 -> pass_mask=2'b01, fail_mask=2'b10, elapsed_out=15, done the next cycle.
- EXPECTED_NONCE=32'h00000001, BACKOFF=2, NUM_CORES=4 -> start nonces FFFFFFFF, FFFFFFFE, FFFFFFFD, FFFFFFFC (wrap checked).
- Assert reset at RUN cycle 7 with core0 already passed -> all outputs 0 asynchronously, state IDLE; a stale golden_valid after reset changes no mask. A new start gives a clean run.
- In DONE with results 2'b11, hold start=1 for 3 cycles -> LOAD, RUN, RUN re-entered; masks cleared; start ignored while busy.

Source files
------------

// File: rtl/hasher_selftest_seq.sv
// hasher_selftest_seq
//
// Built-in known-answer self-test for the serial hasher array. On start it
// loads every core with the same known-answer work unit. Each core gets a
// start nonce a little below the golden nonce, so it hits the golden nonce
// after a few steps. The sequencer then watches each core's golden-nonce
// report and records pass or fail per core, with a RUN-cycle timeout.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-high
//   start            level; begins a test when sampled in IDLE or DONE
//   load_out         one-cycle load strobe per core (LOAD state)
//   midstate_out     known-answer midstate (constant)
//   data_out         known-answer tail data (constant)
//   nonce_load_out   start nonce for core k in bits [32k+31:32k]
//   golden_valid_in  core k reports a found nonce
//   golden_nonce_in  reported nonce, core k slice
//   busy             high in LOAD and RUN
//   done             high in DONE
//   pass_mask        core reported the golden nonce
//   fail_mask        core reported a wrong nonce or timed out
//   elapsed_out      RUN-cycle count at the final decision, or at timeout
module hasher_selftest_seq #(
  parameter int            NUM_CORES      = 2,
  parameter logic [255:0]  MIDSTATE       = 256'h85a24391639705f42f64b3b688df3d147445123c323e62143d87e1908b3f07ef,
  parameter logic [95:0]   DATA           = 96'hc513051a02a99050bfec0373,
  parameter logic [31:0]   EXPECTED_NONCE = 32'h1afda099,
  parameter int            BACKOFF        = 2,
  parameter int            TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic [NUM_CORES-1:0]      load_out,
  output logic [255:0]              midstate_out,
  output logic [95:0]               data_out,
  output logic [32*NUM_CORES-1:0]   nonce_load_out,
  input  logic [NUM_CORES-1:0]      golden_valid_in,
  input  logic [32*NUM_CORES-1:0]   golden_nonce_in,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_CORES-1:0]      pass_mask,
  output logic [NUM_CORES-1:0]      fail_mask,
  output logic [15:0]               elapsed_out
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  localparam logic [15:0] LAST_CYCLE = 16'(TIMEOUT_CYCLES - 1);

  state_t                    state, state_nx;
  logic [15:0]               cnt, cnt_nx;
  logic [NUM_CORES-1:0]      load_nx, pass_nx, fail_nx;
  logic [NUM_CORES-1:0]      match, fresh, decided;
  logic [32*NUM_CORES-1:0]   nonce_nx;
  logic                      busy_nx, done_nx;
  logic [15:0]               elapsed_nx;

  // Core k starts BACKOFF+k below the golden nonce (mod 2^32), so every
  // core must step through at least BACKOFF nonces before hitting it.
  function automatic logic [32*NUM_CORES-1:0] start_nonces();
    logic [32*NUM_CORES-1:0] v;
    v = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      v[32*k +: 32] = EXPECTED_NONCE - 32'(BACKOFF) - 32'(k);
    end
    return v;
  endfunction

  assign midstate_out = MIDSTATE;
  assign data_out     = DATA;

  always_comb begin
    for (int k = 0; k < NUM_CORES; k++) begin
      match[k] = (golden_nonce_in[32*k +: 32] == EXPECTED_NONCE);
    end
  end

  // Only the first report of a core counts; decided cores are masked off.
  assign fresh = golden_valid_in & ~(pass_mask | fail_mask);

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    load_nx    = '0;
    nonce_nx   = nonce_load_out;
    busy_nx    = busy;
    done_nx    = done;
    pass_nx    = pass_mask;
    fail_nx    = fail_mask;
    elapsed_nx = elapsed_out;
    decided    = '0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nx   = S_LOAD;
          load_nx    = '1;
          nonce_nx   = start_nonces();
          busy_nx    = 1'b1;
          done_nx    = 1'b0;
          pass_nx    = '0;
          fail_nx    = '0;
          elapsed_nx = '0;
          cnt_nx     = '0;
        end
      end
      S_LOAD: begin
        state_nx = S_RUN;
        cnt_nx   = '0;
      end
      S_RUN: begin
        pass_nx = pass_mask | (fresh & match);
        fail_nx = fail_mask | (fresh & ~match);
        decided = pass_nx | fail_nx;
        cnt_nx  = cnt + 16'd1;
        // This cycle's reports are folded in before the timeout forces the
        // remaining cores to fail; when all are decided ~decided is zero.
        if ((&decided) || (cnt == LAST_CYCLE)) begin
          fail_nx    = fail_nx | ~decided;
          elapsed_nx = cnt;
          state_nx   = S_DONE;
          busy_nx    = 1'b0;
          done_nx    = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_IDLE;
      cnt            <= '0;
      load_out       <= '0;
      nonce_load_out <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass_mask      <= '0;
      fail_mask      <= '0;
      elapsed_out    <= '0;
    end else begin
      state          <= state_nx;
      cnt            <= cnt_nx;
      load_out       <= load_nx;
      nonce_load_out <= nonce_nx;
      busy           <= busy_nx;
      done           <= done_nx;
      pass_mask      <= pass_nx;
      fail_mask      <= fail_nx;
      elapsed_out    <= elapsed_nx;
    end
  end

endmodule

// File: tb/tb_hasher_selftest_seq.sv
// Testbench for hasher_selftest_seq: directed known-answer scenarios plus
// randomized stub-core report schedules checked against a schedule-level model.
`timescale 1ns/1ps
module tb_hasher_selftest_seq;

  localparam logic [31:0]  EXP = 32'h1afda099;
  localparam int           T   = 16;
  localparam logic [255:0] MID = 256'h85a24391639705f42f64b3b688df3d147445123c323e62143d87e1908b3f07ef;
  localparam logic [95:0]  DAT = 96'hc513051a02a99050bfec0373;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [1:0]   load_out, golden_valid, pass_mask, fail_mask;
  logic [255:0] midstate;
  logic [95:0]  data;
  logic [63:0]  nonce_load, golden_nonce;
  logic         busy, done;
  logic [15:0]  elapsed;

  logic         w_start;
  logic [3:0]   w_load, w_gv, w_pass, w_fail;
  logic [255:0] w_mid;
  logic [95:0]  w_data;
  logic [127:0] w_nonce, w_gn;
  logic         w_busy, w_done;
  logic [15:0]  w_elapsed;

  int n_assert = 0;
  int n_fail   = 0;

  // Stub-core schedule: first report (cycle c1, nonce n1), optional second
  // report (c2, n2). A cycle of -1 means no report.
  int          c1[2], c2[2];
  logic [31:0] n1[2], n2[2];

  always #5 clk = ~clk;

  hasher_selftest_seq #(.NUM_CORES(2), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .start(start), .load_out(load_out),
    .midstate_out(midstate), .data_out(data), .nonce_load_out(nonce_load),
    .golden_valid_in(golden_valid), .golden_nonce_in(golden_nonce),
    .busy(busy), .done(done), .pass_mask(pass_mask), .fail_mask(fail_mask),
    .elapsed_out(elapsed)
  );

  hasher_selftest_seq #(.NUM_CORES(4), .EXPECTED_NONCE(32'h00000001), .BACKOFF(2)) u_wrap (
    .clk(clk), .reset(reset), .start(w_start), .load_out(w_load),
    .midstate_out(w_mid), .data_out(w_data), .nonce_load_out(w_nonce),
    .golden_valid_in(w_gv), .golden_nonce_in(w_gn),
    .busy(w_busy), .done(w_done), .pass_mask(w_pass), .fail_mask(w_fail),
    .elapsed_out(w_elapsed)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input string tag);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk({tag, "/load"},  load_out, 2'b11);
    chk({tag, "/busy"},  busy, 1'b1);
    chk({tag, "/done0"}, done, 1'b0);
    chk({tag, "/nonce"}, nonce_load, {EXP - 32'd3, EXP - 32'd2});
    chk({tag, "/clr"},   {pass_mask, fail_mask, elapsed}, '0);
    @(posedge clk);
  endtask

  task automatic run_case(input string tag);
    logic [1:0] ep, ef;
    int         ee;
    bit         all_dec;
    ep = '0; ef = '0; ee = 0; all_dec = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (c1[k] >= 0 && c1[k] <= T - 1) begin
        if (n1[k] == EXP) ep[k] = 1'b1; else ef[k] = 1'b1;
        if (c1[k] > ee) ee = c1[k];
      end else begin
        all_dec = 1'b0;
      end
    end
    if (!all_dec) begin
      ee = T - 1;
      ef = ef | ~(ep | ef);
    end
    do_start(tag);
    for (int c = 0; c <= ee; c++) begin
      #1;
      for (int k = 0; k < 2; k++) begin
        golden_valid[k] = (c1[k] == c) || (c2[k] == c);
        golden_nonce[32*k +: 32] = (c1[k] == c) ? n1[k] : n2[k];
      end
      @(negedge clk);
      chk({tag, "/excl"}, pass_mask & fail_mask, 2'b00);
      chk({tag, "/run"},  {busy, done}, 2'b10);
      @(posedge clk);
    end
    #1 golden_valid = '0;
    @(negedge clk);
    chk({tag, "/done"},    {busy, done, load_out}, 4'b0100);
    chk({tag, "/pass"},    pass_mask, ep);
    chk({tag, "/fail"},    fail_mask, ef);
    chk({tag, "/elapsed"}, elapsed, 16'(ee));
    chk({tag, "/hold"},    nonce_load, {EXP - 32'd3, EXP - 32'd2});
  endtask

  task automatic set_sched(input int a1, input logic [31:0] a1n, input int a2, input logic [31:0] a2n,
                           input int b1, input logic [31:0] b1n);
    c1[0] = a1; n1[0] = a1n; c2[0] = a2; n2[0] = a2n;
    c1[1] = b1; n1[1] = b1n; c2[1] = -1; n2[1] = '0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; golden_valid = '0; golden_nonce = '0;
    w_start = 1'b0; w_gv = '0; w_gn = '0;
    #12;
    chk("rst/outs", {load_out, nonce_load, busy, done, pass_mask, fail_mask, elapsed}, '0);
    chk("rst/mid",  midstate, MID);
    chk("rst/data", data, DAT);
    @(negedge clk); reset = 1'b0;

    // Known-answer run: both cores pass at cycles 5 and 9.
    set_sched(5, EXP, -1, '0, 9, EXP);
    run_case("kat");
    chk("kat/lit", {pass_mask, fail_mask, elapsed}, {2'b11, 2'b00, 16'd9});

    // Restart from DONE with start held for 3 cycles.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rs/load", {load_out, busy, done}, 4'b1110);
    chk("rs/clr",  {pass_mask, fail_mask, elapsed}, '0);
    @(posedge clk); @(negedge clk);
    chk("rs/run1", {load_out, busy, done}, 4'b0010);
    @(posedge clk); #1 start = 1'b0;
    golden_valid = 2'b11; golden_nonce = {EXP, EXP};
    @(negedge clk);
    chk("rs/run2", {load_out, busy, done}, 4'b0010);
    @(posedge clk); #1 golden_valid = '0;
    @(negedge clk);
    chk("rs/end", {busy, done, pass_mask, fail_mask, elapsed}, {2'b01, 2'b11, 2'b00, 16'd1});

    // Wrong report then ignored correct report on core0.
    set_sched(3, 32'h1afda0af, 4, EXP, 4, EXP);
    run_case("late");
    chk("late/lit", {pass_mask, fail_mask, elapsed}, {2'b10, 2'b01, 16'd4});

    // Timeout: core0 passes in the very last cycle, core1 silent.
    set_sched(15, EXP, -1, '0, -1, '0);
    run_case("tmo");
    chk("tmo/lit", {pass_mask, fail_mask, elapsed}, {2'b01, 2'b10, 16'd15});

    // Start nonce wrap through zero on the 4-core instance.
    @(negedge clk); w_start = 1'b1;
    @(posedge clk); #1 w_start = 1'b0;
    @(negedge clk);
    chk("wrap/load",  w_load, 4'hF);
    chk("wrap/nonce", w_nonce, {32'hFFFFFFFC, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'hFFFFFFFF});

    // Asynchronous reset mid-RUN, then stale reports.
    do_start("ar");
    for (int c = 0; c < 7; c++) begin
      #1 golden_valid = (c == 2) ? 2'b01 : 2'b00; golden_nonce = {32'd0, EXP};
      @(posedge clk);
    end
    #1 golden_valid = '0;
    chk("ar/pre", pass_mask, 2'b01);
    #1 reset = 1'b1;
    #1;
    chk("ar/outs", {load_out, nonce_load, busy, done, pass_mask, fail_mask, elapsed}, '0);
    chk("ar/w",    {w_load, w_nonce, w_busy, w_done, w_pass, w_fail, w_elapsed}, '0);
    @(negedge clk); reset = 1'b0;
    golden_valid = 2'b11; golden_nonce = {EXP, EXP};
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("ar/stale", {busy, done, pass_mask, fail_mask, elapsed}, '0);
    golden_valid = '0;
    set_sched(1, EXP, -1, '0, 6, EXP ^ 32'h10);
    run_case("clean");

    // Randomized schedules.
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 2; k++) begin
        c1[k] = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 18));
        n1[k] = ($urandom_range(0, 2) != 0) ? EXP : (EXP ^ ($urandom | 32'd1));
        if (c1[k] >= 0 && $urandom_range(0, 1) == 1) begin
          c2[k] = c1[k] + int'($urandom_range(1, 3));
          n2[k] = ($urandom_range(0, 1) == 1) ? EXP : $urandom;
        end else begin
          c2[k] = -1; n2[k] = '0;
        end
      end
      run_case($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
